// File: rtl/sprite_loader_pkg.sv
// Shared types and constants for the sprite RAM loader and the colour mapper.
package sprite_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] sprite_addr_t;
  typedef logic [DATA_W-1:0] pal_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK
  } loader_state_t;

  // Solid-colour entries at the top of the sprite RAM
  localparam sprite_addr_t SPR_BG_ADDR      = 11'd1704;
  localparam sprite_addr_t SPR_TERRAIN_ADDR = 11'd1705;
  localparam sprite_addr_t SPR_BLANK_ADDR   = 11'd1706;

  localparam pal_idx_t     PAL_MAX       = 8'd31;
  localparam pal_idx_t     FILL_IDX      = 8'd18;
  localparam pal_idx_t     SYNC_BYTE     = 8'hA5;
  localparam sprite_addr_t RESERVED_BASE = SPR_BG_ADDR;

endpackage

// File: rtl/sprite_loader_if.sv
// Byte-stream input and sprite RAM write port of the loader, with status pulses.
interface sprite_loader_if;
  import sprite_pkg::*;

  pal_idx_t     in_data;
  logic         in_valid;
  logic         in_ready;
  logic         abort;
  logic         we;
  sprite_addr_t write_address;
  pal_idx_t     data_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         range_err;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, we, write_address, data_in, busy, done, err, range_err
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, we, write_address, data_in, busy, done, err, range_err
  );
endinterface

// File: rtl/sprite_loader_write_stage.sv
// Registered sprite RAM write port: palette clamp, sticky range flag, optional
// write protection of the solid-colour entries (SPRITE_LOADER_PROTECT_EN).
module sprite_write_stage
  import sprite_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_req_i,
  input  sprite_addr_t wr_addr_i,
  input  pal_idx_t     wr_byte_i,
  input  logic         clr_range_i,
  output logic         protected_o,
  output logic         we_o,
  output sprite_addr_t addr_o,
  output pal_idx_t     data_o,
  output logic         range_err_o
);

  logic         we_q, range_q;
  sprite_addr_t addr_q;
  pal_idx_t     data_q, data_d;
  logic         out_of_range;

  assign out_of_range = wr_byte_i > PAL_MAX;
  assign data_d       = out_of_range ? FILL_IDX : wr_byte_i;

`ifdef SPRITE_LOADER_PROTECT_EN
  assign protected_o = wr_addr_i >= RESERVED_BASE;
`else
  assign protected_o = 1'b0;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      range_q <= 1'b0;
    end else begin
      we_q <= wr_req_i & ~protected_o;
      if (wr_req_i) begin
        addr_q <= wr_addr_i;
        data_q <= data_d;
      end
      if (clr_range_i)
        range_q <= 1'b0;
      else if (wr_req_i && out_of_range)
        range_q <= 1'b1;
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign range_err_o = range_q;

endmodule

// File: rtl/sprite_loader.sv
// Packet parser that writes palette indices into sprite RAM from a byte stream.
// Optional: SPRITE_LOADER_PROTECT_EN blocks writes at or above the solid-colour entries.
module sprite_loader
  import sprite_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  sprite_loader_if.slave  bus
);

  loader_state_t state_q, state_d;
  sprite_addr_t  addr_q, addr_d;
  logic [10:0]   len_q, len_d;
  pal_idx_t      chk_q, chk_d;
  logic          prot_q, prot_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rdy_q;
  logic          xfer, wr_req, clr_range, addr_protected;

  // abort discards whatever byte is on the bus in the same cycle
  assign xfer = bus.in_valid & rdy_q & ~bus.abort;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    chk_d     = chk_q;
    prot_d    = prot_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_req    = 1'b0;
    clr_range = 1'b0;
    case (state_q)
      IDLE:
        if (xfer && bus.in_data == SYNC_BYTE) begin
          state_d   = ADDR_HI;
          chk_d     = '0;
          prot_d    = 1'b0;
          clr_range = 1'b1;
        end
      ADDR_HI: if (xfer) begin addr_d = {bus.in_data[2:0], addr_q[7:0]}; state_d = ADDR_LO; end
      ADDR_LO: if (xfer) begin addr_d = {addr_q[10:8], bus.in_data};     state_d = LEN_HI;  end
      LEN_HI:  if (xfer) begin len_d  = {bus.in_data[2:0], len_q[7:0]};  state_d = LEN_LO;  end
      LEN_LO:
        if (xfer) begin
          len_d = {len_q[10:8], bus.in_data};
          if (len_d == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      DATA:
        if (xfer) begin
          wr_req = 1'b1;
          addr_d = addr_q + 11'd1;
          chk_d  = chk_q ^ bus.in_data;
          len_d  = len_q - 11'd1;
          prot_d = prot_q | addr_protected;
          if (len_q == 11'd1) state_d = CHK;
        end
      CHK:
        if (xfer) begin
          if (bus.in_data == chk_q && !prot_q) done_d = 1'b1;
          else                                 err_d  = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      chk_q   <= '0;
      prot_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      prot_q  <= prot_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  sprite_write_stage u_write_stage (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_req_i    (wr_req),
    .wr_addr_i   (addr_q),
    .wr_byte_i   (bus.in_data),
    .clr_range_i (clr_range),
    .protected_o (addr_protected),
    .we_o        (bus.we),
    .addr_o      (bus.write_address),
    .data_o      (bus.data_in),
    .range_err_o (bus.range_err)
  );

  assign bus.in_ready = rdy_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: packet table plus abort/reset sequences,
// with a write scoreboard fed by a reference model of address/clamp/protect.
module tb_sprite_loader;
  import sprite_pkg::*;

`ifdef SPRITE_LOADER_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sprite_loader_if bus();

  sprite_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [15:0] pre;
    int          npre;
    logic [7:0]  ahi, alo, lhi, llo;
    logic [31:0] pay;
    logic [7:0]  chk;
    bit          exp_done, exp_err, exp_range;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   total = 0, bad = 0;
  int   done_cnt = 0, err_cnt = 0;
  bit   both_seen = 1'b0;
  bit   prot_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.done && bus.err) both_seen = 1'b1;
      if (bus.we) begin
        if (exp_q.size() == 0) begin
          check("write_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.write_address), 32'(e.addr));
          check("wr_data", 32'(bus.data_in), 32'(e.data));
        end
      end
    end
  end

  // reference model of one payload write
  task automatic expect_write(input logic [10:0] a, input logic [7:0] b);
    wr_t w;
    if (PROT && a >= 11'd1704) begin
      prot_hit = 1'b1;
    end else begin
      w.addr = a;
      w.data = (b > 8'd31) ? 8'd18 : b;
      exp_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ab);
    int n;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.abort    = ab;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_header(input logic [7:0] ahi, alo, lhi, llo);
    send_byte(8'hA5, 1'b0);
    send_byte(ahi, 1'b0);
    send_byte(alo, 1'b0);
    send_byte(lhi, 1'b0);
    send_byte(llo, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int d0, e0, len;
    logic [10:0] start;
    d0 = done_cnt;
    e0 = err_cnt;
    prot_hit = 1'b0;
    for (int i = 0; i < v.npre; i++) send_byte(v.pre[8*i +: 8], 1'b0);
    send_header(v.ahi, v.alo, v.lhi, v.llo);
    len   = int'({v.lhi[2:0], v.llo});
    start = {v.ahi[2:0], v.alo};
    for (int i = 0; i < len; i++) begin
      expect_write(start + 11'(i), v.pay[8*i +: 8]);
      send_byte(v.pay[8*i +: 8], 1'b0);
    end
    if (len != 0) send_byte(v.chk, 1'b0);
    go_idle(3);
    check({name, "_done"}, 32'(done_cnt - d0), 32'(v.exp_done && !prot_hit));
    check({name, "_err"}, 32'(err_cnt - e0), 32'(v.exp_err || prot_hit));
    check({name, "_range"}, 32'(bus.range_err), 32'(v.exp_range));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int d0, e0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;

    vecs[0] = '{16'h0, 0, 8'h00, 8'h10, 8'h00, 8'h03, 32'h001D0705, 8'h1F, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0, 0, 8'h07, 8'hFF, 8'h00, 8'h02, 32'h00000201, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 32'h00000430, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h2211, 2, 8'h00, 8'h20, 8'h00, 8'h01, 32'h0000001F, 8'h1F, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0, 0, 8'hFD, 8'h00, 8'hF8, 8'h02, 32'h0000201F, 8'h3F, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0, 0, 8'h06, 8'hA8, 8'h00, 8'h02, 32'h00001515, 8'h00, 1'b1, 1'b0, 1'b0};

    #2;
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_addr", 32'(bus.write_address), 32'd0);
    check("rst_data", 32'(bus.data_in), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("rst_range", 32'(bus.range_err), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort on the 2nd payload byte of a 4-byte packet
    d0 = done_cnt; e0 = err_cnt;
    send_header(8'h00, 8'h40, 8'h00, 8'h04);
    expect_write(11'd64, 8'h03);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    go_idle(3);
    check("abort_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    run_vec(vecs[0], "after_abort");

    // abort coinciding with a good checksum byte
    d0 = done_cnt; e0 = err_cnt;
    send_header(8'h00, 8'h50, 8'h00, 8'h01);
    expect_write(11'd80, 8'h07);
    send_byte(8'h07, 1'b0);
    send_byte(8'h07, 1'b1);
    go_idle(3);
    check("abort_chk_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    check("abort_chk_idle", 32'(bus.busy), 32'd0);

    // reset mid-DATA with a write registered but not yet seen
    send_header(8'h00, 8'h00, 8'h00, 8'h04);
    expect_write(11'd0, 8'h40);
    send_byte(8'h40, 1'b0);
    send_byte(8'h01, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_we", 32'(bus.we), 32'd1);
    check("pre_reset_range", 32'(bus.range_err), 32'd1);
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.we), 32'd0);
    check("mid_rst_addr", 32'(bus.write_address), 32'd0);
    check("mid_rst_data", 32'(bus.data_in), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_range", 32'(bus.range_err), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], "after_reset");

    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("done_err_together", 32'(both_seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
